// File: rtl/ddr3_upload_arb.sv
// rtl/ddr3_upload_arb.sv - round-robin arbiter sharing one DDR3 upload port among N_REQ requesters
//
// Requesters: 0 = debug dump, 1 = SRAM save, 2 = config dump (N_REQ 2..4).
// Optional feature macro: UPLOAD_ARB_TIMEOUT_EN (16-bit per-session idle watchdog).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   req_upload   per-requester session request, held for the whole transfer
//   req_wr       per-requester single-cycle write strobe
//   req_addr     per-requester 28-bit byte address, requester g at [g*28 +: 28]
//   req_din      per-requester 8-bit data, requester g at [g*8 +: 8]
//   req_ready    per-requester permission to strobe (combinational, owner only)
//   ddr3_addr    shared port address (registered, holds between writes)
//   ddr3_din     shared port data (registered, holds between writes)
//   ddr3_upload  shared port session flag (registered)
//   ddr3_wr      shared port write pulse (registered, one cycle)
//   ddr3_ready   shared port ready
//   grant_id     current owner index, valid while busy
//   busy         high whenever the arbiter is not idle
//   timeout      sticky watchdog flag (constant 0 without the macro)

module ddr3_upload_arb #(
  parameter int N_REQ = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_upload,
  input  logic [N_REQ-1:0]     req_wr,
  input  logic [N_REQ*28-1:0]  req_addr,
  input  logic [N_REQ*8-1:0]   req_din,
  output logic [N_REQ-1:0]     req_ready,
  output logic [27:0]          ddr3_addr,
  output logic [7:0]           ddr3_din,
  output logic                 ddr3_upload,
  output logic                 ddr3_wr,
  input  logic                 ddr3_ready,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WRITE,
    S_RELEASE
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  last_grant, last_grant_nxt;
  logic [1:0]  grant_nxt;
  logic        upload_nxt;
  logic        wr_nxt;
  logic [27:0] addr_nxt;
  logic [7:0]  din_nxt;

  // Owner view of the requester buses.
  logic [N_REQ-1:0] owner_sel;
  logic             owner_upload;
  logic             owner_wr;
  logic [27:0]      owner_addr;
  logic [7:0]       owner_din;

  // Round-robin pick.
  logic [N_REQ-1:0] eligible;
  logic [1:0]       pick;
  logic             pick_valid;
  int               rr_idx;

`ifdef UPLOAD_ARB_TIMEOUT_EN
  logic [15:0]      idle_cnt, idle_cnt_nxt;
  logic             timeout_q, timeout_nxt;
  // A requester that timed out is ignored until it lowers req_upload.
  logic [N_REQ-1:0] stalled, stalled_nxt;

  assign eligible = req_upload & ~stalled;
  assign timeout  = timeout_q;
`else
  assign eligible = req_upload;
  assign timeout  = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  always_comb begin
    owner_sel    = '0;
    owner_upload = 1'b0;
    owner_wr     = 1'b0;
    owner_addr   = '0;
    owner_din    = '0;
    for (int g = 0; g < N_REQ; g++) begin
      if (grant_id == 2'(g)) begin
        owner_sel[g] = 1'b1;
        owner_upload = req_upload[g];
        owner_wr     = req_wr[g];
        owner_addr   = req_addr[g*28 +: 28];
        owner_din    = req_din[g*8 +: 8];
      end
    end
  end

  assign req_ready = owner_sel & req_upload & {N_REQ{(state == S_GRANT) && ddr3_ready}};

  // Scan from last_grant+1 so the previous owner is considered last.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    rr_idx     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_idx = (int'(last_grant) + i) % N_REQ;
      if (!pick_valid && eligible[rr_idx]) begin
        pick       = 2'(rr_idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    upload_nxt     = ddr3_upload;
    wr_nxt         = 1'b0;
    addr_nxt       = ddr3_addr;
    din_nxt        = ddr3_din;
`ifdef UPLOAD_ARB_TIMEOUT_EN
    idle_cnt_nxt   = idle_cnt;
    timeout_nxt    = timeout_q;
    stalled_nxt    = stalled & req_upload;
`endif
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          grant_nxt  = pick;
          upload_nxt = 1'b1;
          state_nxt  = S_GRANT;
`ifdef UPLOAD_ARB_TIMEOUT_EN
          idle_cnt_nxt = '0;
`endif
        end
      end
      S_GRANT: begin
        // The write is checked before the drop so a strobe on the same
        // cycle as the owner lowering req_upload still reaches DDR3.
        if (owner_wr && ddr3_ready) begin
          addr_nxt  = owner_addr;
          din_nxt   = owner_din;
          wr_nxt    = 1'b1;
          state_nxt = S_WRITE;
`ifdef UPLOAD_ARB_TIMEOUT_EN
          idle_cnt_nxt = '0;
`endif
        end else if (!owner_upload) begin
          upload_nxt     = 1'b0;
          last_grant_nxt = grant_id;
          state_nxt      = S_RELEASE;
        end
`ifdef UPLOAD_ARB_TIMEOUT_EN
        else if (idle_cnt == 16'hFFFF) begin
          timeout_nxt    = 1'b1;
          upload_nxt     = 1'b0;
          last_grant_nxt = grant_id;
          stalled_nxt    = (stalled & req_upload) | owner_sel;
          state_nxt      = S_RELEASE;
        end else if (!owner_wr) begin
          idle_cnt_nxt = idle_cnt + 16'd1;
        end
`endif
      end
      S_WRITE: begin
        state_nxt = S_GRANT;
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      grant_id    <= '0;
      last_grant  <= 2'(N_REQ - 1);
      ddr3_upload <= 1'b0;
      ddr3_wr     <= 1'b0;
      ddr3_addr   <= '0;
      ddr3_din    <= '0;
    end else begin
      state       <= state_nxt;
      grant_id    <= grant_nxt;
      last_grant  <= last_grant_nxt;
      ddr3_upload <= upload_nxt;
      ddr3_wr     <= wr_nxt;
      ddr3_addr   <= addr_nxt;
      ddr3_din    <= din_nxt;
    end
  end

`ifdef UPLOAD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
      stalled   <= '0;
    end else begin
      idle_cnt  <= idle_cnt_nxt;
      timeout_q <= timeout_nxt;
      stalled   <= stalled_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_upload_arb.sv
// tb/tb_ddr3_upload_arb.sv - directed self-checking bench for ddr3_upload_arb

module tb_ddr3_upload_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_upload;
  logic [2:0]  req_wr;
  logic [83:0] req_addr;
  logic [23:0] req_din;
  logic [2:0]  req_ready;
  logic [27:0] ddr3_addr;
  logic [7:0]  ddr3_din;
  logic        ddr3_upload;
  logic        ddr3_wr;
  logic        ddr3_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout;

  int total = 0;
  int bad   = 0;
  int o;
  logic [27:0] exp_addr;
  logic [7:0]  exp_din;

  ddr3_upload_arb #(.N_REQ(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_upload  (req_upload),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_din     (req_din),
    .req_ready   (req_ready),
    .ddr3_addr   (ddr3_addr),
    .ddr3_din    (ddr3_din),
    .ddr3_upload (ddr3_upload),
    .ddr3_wr     (ddr3_wr),
    .ddr3_ready  (ddr3_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic drive(input int r, input logic [27:0] a, input logic [7:0] d);
    req_wr               = '0;
    req_wr[r]            = 1'b1;
    req_addr[r*28 +: 28] = a;
    req_din[r*8 +: 8]    = d;
  endtask

  initial begin
    reset      = 1'b0;
    req_upload = '0;
    req_wr     = '0;
    req_addr   = '0;
    req_din    = '0;
    ddr3_ready = 1'b1;
    tick();
    tick();
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_upload",  32'(ddr3_upload), 32'd0);
    chk("rst_wr",      32'(ddr3_wr),     32'd0);
    chk("rst_addr",    32'(ddr3_addr),   32'd0);
    chk("rst_din",     32'(ddr3_din),    32'd0);
    chk("rst_grant",   32'(grant_id),    32'd0);
    chk("rst_ready",   32'(req_ready),   32'd0);
    chk("rst_timeout", 32'(timeout),     32'd0);
    reset = 1'b1;

    // Single owner
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    req_upload = 3'b001;
    tick();
    chk("s1_upload", 32'(ddr3_upload), 32'd1);
    chk("s1_grant",  32'(grant_id),    32'd0);
    chk("s1_ready",  32'(req_ready),   32'b001);
    chk("s1_nowr",   32'(ddr3_wr),     32'd0);
    drive(0, 28'h1400000, 8'hA5);
    tick();
    chk("s1_wr",       32'(ddr3_wr),   32'd1);
    chk("s1_addr",     32'(ddr3_addr), 32'h1400000);
    chk("s1_din",      32'(ddr3_din),  32'hA5);
    chk("s1_ready_wr", 32'(req_ready), 32'd0);
    req_wr = '0;
    tick();
    chk("s1_wr_off",   32'(ddr3_wr),   32'd0);
    chk("s1_addr_hold",32'(ddr3_addr), 32'h1400000);
    req_upload = '0;
    tick();
    chk("s1_rel_upload", 32'(ddr3_upload), 32'd0);
    chk("s1_rel_busy",   32'(busy),        32'd1);
    tick();
    chk("s1_idle_busy",  32'(busy),        32'd0);

    // Contention from reset: order 0,1,2,0
    reset = 1'b0;
    req_upload = 3'b111;
    tick();
    reset = 1'b1;
    for (int s = 0; s < 4; s++) begin
      o = s % 3;
      tick();
      chk("ct_grant",  32'(grant_id),    32'(o));
      chk("ct_upload", 32'(ddr3_upload), 32'd1);
      chk("ct_ready",  32'(req_ready),   32'(1 << o));
      for (int w = 0; w < 2; w++) begin
        exp_addr = 28'h0200000 + 28'(s * 16 + w);
        exp_din  = 8'(s * 16 + w);
        drive(o, exp_addr, exp_din);
        tick();
        chk("ct_wr",   32'(ddr3_wr),   32'd1);
        chk("ct_addr", 32'(ddr3_addr), 32'(exp_addr));
        chk("ct_din",  32'(ddr3_din),  32'(exp_din));
        req_wr = '0;
        tick();
        chk("ct_wr_off",    32'(ddr3_wr),  32'd0);
        chk("ct_grant_hold",32'(grant_id), 32'(o));
      end
      req_upload[o] = 1'b0;
      tick();
      chk("ct_rel_upload", 32'(ddr3_upload), 32'd0);
      chk("ct_rel_busy",   32'(busy),        32'd1);
      req_upload = (s == 3) ? 3'b000 : 3'b111;
      tick();
      chk("ct_idle_busy",  32'(busy),        32'd0);
    end

    // Backpressure on owner 1 (requester 0 also waiting, skipped by round robin)
    req_upload = 3'b011;
    tick();
    chk("bp_grant", 32'(grant_id), 32'd1);
    ddr3_ready = 1'b0;
    #1;
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive(1, 28'h0DEAD00, 8'hDD);
      else req_wr = '0;
      tick();
      chk("bp_nowr",  32'(ddr3_wr),   32'd0);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    req_wr = '0;
    ddr3_ready = 1'b1;
    #1;
    chk("bp_ready_back", 32'(req_ready), 32'b010);
    drive(0, 28'h0FFFFFF, 8'hEE);
    tick();
    chk("nonowner_wr",   32'(ddr3_wr),   32'd0);
    chk("nonowner_addr", 32'(ddr3_addr), 32'h0200031);
    chk("nonowner_din",  32'(ddr3_din),  32'h31);
    drive(1, 28'h0ABCDEF, 8'h5A);
    tick();
    chk("bp_wr",   32'(ddr3_wr),   32'd1);
    chk("bp_addr", 32'(ddr3_addr), 32'h0ABCDEF);
    chk("bp_din",  32'(ddr3_din),  32'h5A);
    req_wr = '0;
    tick();
    chk("bp_wr_off", 32'(ddr3_wr), 32'd0);

    // Owner 1 drops request on the same cycle as a write
    drive(1, 28'h0123456, 8'h3C);
    req_upload = 3'b001;
    tick();
    chk("dw_wr",     32'(ddr3_wr),     32'd1);
    chk("dw_din",    32'(ddr3_din),    32'h3C);
    chk("dw_upload", 32'(ddr3_upload), 32'd1);
    req_wr = '0;
    tick();
    chk("dw_wr_off",  32'(ddr3_wr),     32'd0);
    chk("dw_upload1", 32'(ddr3_upload), 32'd1);
    tick();
    chk("dw_upload0", 32'(ddr3_upload), 32'd0);
    chk("dw_busy",    32'(busy),        32'd1);
    tick();
    chk("dw_idle", 32'(busy), 32'd0);
    tick();
    chk("dw_next_grant", 32'(grant_id),    32'd0);
    chk("dw_next_up",    32'(ddr3_upload), 32'd1);

    // Reset while in WRITE
    drive(0, 28'h0000777, 8'h77);
    tick();
    chk("rw_wr", 32'(ddr3_wr), 32'd1);
    reset      = 1'b0;
    req_wr     = '0;
    req_upload = 3'b111;
    #1;
    chk("rw_wr0",     32'(ddr3_wr),     32'd0);
    chk("rw_upload0", 32'(ddr3_upload), 32'd0);
    chk("rw_busy0",   32'(busy),        32'd0);
    tick();
    chk("rw_held", 32'(ddr3_upload), 32'd0);
    reset = 1'b1;
    tick();
    chk("rw_grant",  32'(grant_id),    32'd0);
    chk("rw_upload", 32'(ddr3_upload), 32'd1);
    req_upload = '0;
    tick();
    tick();
    chk("rw_idle", 32'(busy), 32'd0);

    // Watchdog
    req_upload = 3'b001;
    tick();
    chk("wd_grant",  32'(grant_id),    32'd0);
    chk("wd_upload", 32'(ddr3_upload), 32'd1);
`ifdef UPLOAD_ARB_TIMEOUT_EN
    repeat (65535) tick();
    chk("wd_pre_to",     32'(timeout),     32'd0);
    chk("wd_pre_upload", 32'(ddr3_upload), 32'd1);
    tick();
    chk("wd_to",        32'(timeout),     32'd1);
    chk("wd_to_upload", 32'(ddr3_upload), 32'd0);
    chk("wd_to_busy",   32'(busy),        32'd1);
    tick();
    chk("wd_idle", 32'(busy), 32'd0);
    tick();
    chk("wd_ignored", 32'(busy), 32'd0);
    req_upload = 3'b010;
    tick();
    chk("wd_next_grant", 32'(grant_id),    32'd1);
    chk("wd_next_up",    32'(ddr3_upload), 32'd1);
    chk("wd_sticky",     32'(timeout),     32'd1);
`else
    repeat (200) tick();
    chk("nto_timeout", 32'(timeout),     32'd0);
    chk("nto_upload",  32'(ddr3_upload), 32'd1);
    chk("nto_busy",    32'(busy),        32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr3_upload_arb.md
DDR3_UPLOAD_ARB -- requirements
Module: ddr3_upload_arb

Interface
REQ-001 Parameter N_REQ, default 3, number of upload requesters (2..4); requester 0 is the debug dump, 1 the SRAM save, 2 the config dump.
REQ-002 clk  in  1  system clock; all logic is on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_upload  in  N_REQ  per-requester session request, held high for the whole transfer.
REQ-005 req_wr  in  N_REQ  per-requester single-cycle write strobe.
REQ-006 req_addr  in  N_REQ x 28  per-requester DDR3 byte address.
REQ-007 req_din  in  N_REQ x 8  per-requester write data.
REQ-008 req_ready  out  N_REQ  per-requester permission to strobe the next write.
REQ-009 ddr3_addr  out  28  shared port address, registered.
REQ-010 ddr3_din  out  8  shared port data, registered.
REQ-011 ddr3_upload  out  1  shared port session flag, registered.
REQ-012 ddr3_wr  out  1  shared port write pulse, registered.
REQ-013 ddr3_ready  in  1  shared port ready.
REQ-014 grant_id  out  2  index of the current owner; valid while busy.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout  out  1  sticky watchdog flag; exists only with the macro (REQ-034).

Function
REQ-017 The FSM SHALL have states IDLE, GRANT, WRITE and RELEASE.
REQ-018 IDLE, when any req_upload bit is high: select the first requesting index scanning round-robin from last_grant+1 modulo N_REQ; load grant_id; set ddr3_upload=1 on the next edge; enter GRANT.
REQ-019 IDLE with no request: the FSM SHALL stay in IDLE with all outputs at reset values.
REQ-020 req_ready[g] SHALL be combinational: (state==GRANT) & ddr3_ready & req_upload[g], for g==grant_id only; every other bit SHALL be 0.
REQ-021 GRANT, on req_wr[g] with req_ready[g] high: latch req_addr[g] and req_din[g] into ddr3_addr/ddr3_din; set ddr3_wr=1 on the same edge; enter WRITE.
REQ-022 WRITE SHALL clear ddr3_wr after exactly one cycle and return to GRANT; ddr3_wr is therefore never asserted for two consecutive cycles.
REQ-023 Write latency: the ddr3_wr rising edge SHALL be registered from the req_wr cycle, one edge later.
REQ-024 The arbiter SHALL ignore req_wr from a non-owner, and from the owner while req_ready is low; no DDR3 write results.
REQ-025 GRANT, owner req_upload low: clear ddr3_upload; store last_grant=grant_id; enter RELEASE.
REQ-026 RELEASE SHALL last one cycle and then go to IDLE; re-arbitration happens no earlier than the cycle after RELEASE.
REQ-027 If the owner drops req_upload on the same cycle as req_wr, the write SHALL complete (WRITE) first and the release SHALL be taken from GRANT afterwards.
REQ-028 The grant SHALL never change mid-session; new requests wait until RELEASE.
REQ-029 With several requesters permanently high, each SHALL receive a session within N_REQ consecutive sessions.
REQ-030 ddr3_addr and ddr3_din SHALL hold their last value between writes.

Reset
REQ-031 Asynchronous assertion SHALL force state=IDLE, ddr3_upload=0, ddr3_wr=0, ddr3_addr=0, ddr3_din=0, grant_id=0, last_grant=N_REQ-1 (so requester 0 wins first), timeout=0.
REQ-032 Reset mid-session SHALL drop ddr3_upload and ddr3_wr immediately without completing the pending write.
REQ-033 After release, the first arbitration SHALL occur on the first clk edge with reset high.

Configuration
REQ-034 Macro UPLOAD_ARB_TIMEOUT_EN. When defined: a 16-bit idle counter clears on each owner write and on each grant, and increments in GRANT while there is no req_wr.
REQ-035 When defined, reaching 16'hFFFF SHALL set timeout (sticky until reset), clear ddr3_upload and enter RELEASE; the owner stays ignored until its req_upload goes low.
REQ-036 When not defined, there SHALL be no counter, timeout SHALL be tied to 0, and a session is unlimited.

Verification
REQ-037 Single owner: req_upload[0]=1, write addr 28'h1400000 data 8'hA5 with ddr3_ready=1 -> ddr3_upload rises one cycle after the request, one ddr3_wr pulse carries 28'h1400000/8'hA5, grant_id=0.
REQ-038 Contention: all three requests high from reset, each doing 2 writes then dropping -> sessions granted in order 0, 1, 2, 0; no overlap; one RELEASE cycle between sessions.
REQ-039 Backpressure: ddr3_ready=0 for 5 cycles in GRANT -> req_ready low and no ddr3_wr; a strobe in that window is ignored; the write goes through after ready returns.
REQ-040 Simultaneous drop and write on owner 1 with data 8'h3C -> the write completes, then ddr3_upload falls two cycles later.
REQ-041 Reset asserted in WRITE -> ddr3_wr and ddr3_upload are 0 at once; after release, requester 0 is granted first.
REQ-042 With UPLOAD_ARB_TIMEOUT_EN: owner holds req_upload with no writes for 65535 cycles -> timeout=1, ddr3_upload=0, and the next requester is granted once the stalled requester drops its request.
